match_tally: RTL
================

# match_tally

Downstream consumer of the 1→2→3 sequence detector's 1-bit `ans` output. Tallies distinct detection events (rising edges of `ans`), measures how many consecutive cycles `ans` stays high, records the longest such run, and raises a sticky alarm once a programmable number of detections has occurred. All outputs are registered. The outputs feed status and display logic.

## Interface
Parameters:
- `WIDTH`, default 8: width of `count`, `run`, and `max_run`.
- `THRESH`, default 4: detection count at which `alarm` sets. Legal range is 1 to 2^WIDTH−1.

Ports:
- `clk`, input, 1: system clock. All state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `ans`, input, 1: detector output. Sampled on every `clk` rising edge.
- `en`, input, 1: enable. When 0, all state and outputs hold, except `hit`, which is 0.
- `clr`, input, 1: synchronous clear of tallies and alarm. Does not restart an in-progress run as a new detection.
- `count`, output, WIDTH: number of detections. Saturating.
- `run`, output, WIDTH: length of the current `ans`-high run. 0 while `ans` is low. Saturating.
- `max_run`, output, WIDTH: longest run seen since the last reset or clear.
- `hit`, output, 1: one-cycle pulse marking a counted detection.
- `alarm`, output, 1: sticky flag, set when `count` reaches `THRESH`.
- `sat`, output, 1: sticky flag, set when `count` saturates.

## Operation
- **State machine:** the only state register is `st`, with three states: IDLE, RUN, HOLD.
- **Update priority** on each edge, highest first: `reset`, then `clr`, then `en`=0 (hold), then normal update.
- **Reset:** `st`=IDLE. `count`, `run`, `max_run` = 0. `hit`, `alarm`, `sat` = 0.
- **Clear (`clr`=1):**
  - `count`, `run`, `max_run` = 0. `hit`, `alarm`, `sat` = 0.
  - `st` = HOLD if `ans`=1, otherwise IDLE. A run already in progress is never counted twice.
  - `clr` acts regardless of `en`.
- **Normal update (`en`=1, no clear):**
  - IDLE, `ans`=1: go to RUN. Increment `count` (saturating). `run`=1. `hit`=1.
  - IDLE, `ans`=0: stay IDLE. `run`=0. `hit`=0.
  - RUN, `ans`=1: stay RUN. Increment `run` (saturating). `hit`=0.
  - RUN, `ans`=0: go to IDLE. `run`=0. `hit`=0.
  - HOLD, `ans`=1: stay HOLD. Increment `run`. Do not touch `count`.
  - HOLD, `ans`=0: go to IDLE. `run`=0.
- **`max_run`:** on every enabled edge, set `max_run` to the larger of `max_run` and the new `run` value (the value being written this edge). `max_run` therefore always equals or exceeds `run` on the same cycle.
- **`alarm`:** set on the edge where the new `count` equals `THRESH`. Stays set until `reset` or `clr`.
- **Saturation:** when `count` = 2^WIDTH−1, further detections leave `count` unchanged but still pulse `hit`. `sat` sets on the edge where `count` first becomes 2^WIDTH−1.
- **Run saturation:** `run` stops at 2^WIDTH−1. This does not set `sat`.
- **Width:** all arithmetic is unsigned, WIDTH bits. Comparisons use the post-increment value.
- **Illegal state** (encoding outside the three states): go to IDLE on the next enabled edge.

## Timing
- **Latency:** one cycle. For `ans` sampled at edge k, `count`, `run`, and `hit` reflect it during cycle k+1.
- **`hit`:** high for exactly one cycle per detection. It never stays high for two consecutive cycles, because a detection requires a prior `ans`=0 sample or a clear.
- **Back-to-back pattern** `ans` = 1,0,1: two hits, at cycles k+1 and k+3. `count` increments by 2.
- **`en` deasserted mid-run:** the run resumes counting when `en` returns. An `ans` falling edge that happens while `en`=0 and rises again before `en` returns is not seen. Intentional.
- **`reset` while `ans`=1:** next enabled edge with `ans`=1 counts as a new detection (`st` starts in IDLE).
- **`clr` and `reset` together:** reset wins, so `st`=IDLE, not HOLD.

## Test plan
- **Reset and idle:** `reset`=1 for 2 cycles, then `ans`=0 for 5 cycles → all outputs 0 throughout.
- **Single run:** `ans` high for 3 cycles, then low → `hit`=1 for one cycle only. `run` goes 1,2,3,0. `count`=1. `max_run`=3.
- **Alarm:** 4 separate 1-cycle pulses with `THRESH`=4 → `alarm` rises in the cycle after the 4th pulse's edge. `clr` then → `alarm`=0, `count`=0.
- **Clear mid-run:** `ans` high 5 cycles, `clr` pulsed at cycle 2 → one `hit` only (before the clear). After the clear, `count`=0, `run` restarts at 0 and reaches 3, `max_run`=3, `st` passes through HOLD.
- **Saturation with `WIDTH`=2:** 4 detections → `count` stays at 3, `sat`=1, 4th `hit` still pulses. A run of 5 cycles → `run` and `max_run` stop at 3.
- **Enable gating:** `ans` toggles 1,0,1,0 with `en`=0 → no change and `hit`=0. Repeat with `en`=1 → `count`=2.

Source files
------------

// File: rtl/match_tally.sv
// Tallies rising edges of a detector's ans output, tracks current/longest high run,
// and raises sticky alarm/saturation flags. All outputs are registered.
module match_tally #(
  parameter int WIDTH  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ans,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] run,
  output logic [WIDTH-1:0] max_run,
  output logic             hit,
  output logic             alarm,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } st_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = '0;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == ALL_ONES) ? v : v + ONE_W;
  endfunction

  st_t              st_r;
  st_t              st_s;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] run_s;
  logic [WIDTH-1:0] max_run_s;
  logic             hit_s;
  logic             alarm_s;
  logic             sat_s;

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_r    <= IDLE;
      count   <= ZERO_W;
      run     <= ZERO_W;
      max_run <= ZERO_W;
      hit     <= 1'b0;
      alarm   <= 1'b0;
      sat     <= 1'b0;
    end else begin
      st_r    <= st_s;
      count   <= count_s;
      run     <= run_s;
      max_run <= max_run_s;
      hit     <= hit_s;
      alarm   <= alarm_s;
      sat     <= sat_s;
    end
  end

  // Next-state and next-output logic: clear, then enable hold, then normal update.
  always_comb begin
    st_s      = st_r;
    count_s   = count;
    run_s     = run;
    max_run_s = max_run;
    hit_s     = 1'b0;
    alarm_s   = alarm;
    sat_s     = sat;
    if (clr) begin
      // An ans already high lands in HOLD so it is not counted again.
      st_s      = ans ? HOLD : IDLE;
      count_s   = ZERO_W;
      run_s     = ZERO_W;
      max_run_s = ZERO_W;
      alarm_s   = 1'b0;
      sat_s     = 1'b0;
    end else if (!en) begin
      hit_s = 1'b0;
    end else begin
      case (st_r)
        IDLE: begin
          if (ans) begin
            st_s    = RUN;
            count_s = sat_inc(count);
            run_s   = ONE_W;
            hit_s   = 1'b1;
          end else begin
            run_s = ZERO_W;
          end
        end
        RUN, HOLD: begin
          if (ans) begin
            run_s = sat_inc(run);
          end else begin
            st_s  = IDLE;
            run_s = ZERO_W;
          end
        end
        default: begin
          st_s  = IDLE;
          run_s = ZERO_W;
        end
      endcase
      if (run_s > max_run) begin
        max_run_s = run_s;
      end else begin
        max_run_s = max_run;
      end
      if (hit_s && (count_s == THRESH_W)) begin
        alarm_s = 1'b1;
      end else begin
        alarm_s = alarm;
      end
      if (hit_s && (count_s == ALL_ONES)) begin
        sat_s = 1'b1;
      end else begin
        sat_s = sat;
      end
    end
  end

endmodule
